// File: rtl/elevator_controller.sv
// elevator_controller: single-car call latching, floor/direction sequencing, move pulses and timed doors.
// Optional macro FIRE_RECALL_EN adds the fire_recall input (drive the car to floor 0 and hold the door).
module elevator_controller #(
  parameter int MOVE_CYCLES = 2,
  parameter int DOOR_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
`ifdef FIRE_RECALL_EN
  input  logic       fire_recall,
`endif
  input  logic [7:0] call_in_req,
  input  logic [7:0] call_up_req,
  input  logic [7:0] call_down_req,
  output logic [7:0] call_in,
  output logic [7:0] call_up,
  output logic [7:0] call_down,
  output logic [2:0] cur_floor,
  output logic       direction,
  output logic       move,
  output logic       door_open,
  output logic       idle
);
  localparam int MW = $clog2(MOVE_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [MW-1:0] M_LAST = MW'(MOVE_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, MOVING, ARRIVE, DOOR} state_t;
  state_t state, nxt;
  logic [MW-1:0] mcnt;
  logic [DW-1:0] dcnt;
  logic [7:0] any, fbit, hall_dir, hall_opp, clr_in, clr_up, clr_dn;
  logic above, below, here_dir, here_opp, ahead, behind, dir_n, recall, at_bottom;
`ifdef FIRE_RECALL_EN
  assign recall = fire_recall;
`else
  assign recall = 1'b0;
`endif
  always_comb begin
    fbit = 8'h01 << cur_floor;
    any = call_in | call_up | call_down;
    above = |(any & (8'hfe << cur_floor));
    below = |(any & ~(8'hff << cur_floor));
    hall_dir = direction ? call_up : call_down;
    hall_opp = direction ? call_down : call_up;
    here_dir = |(fbit & (call_in | hall_dir));
    here_opp = |(fbit & hall_opp);
    ahead = direction ? above : below;
    behind = direction ? below : above;
    at_bottom = cur_floor == 3'd0;
    move = state == MOVING && mcnt == M_LAST;
    door_open = state == DOOR;
    idle = state == IDLE && any == 8'h00;
    nxt = state;
    dir_n = direction;
    case (state)
      IDLE, ARRIVE:
        if (recall) begin
          dir_n = 1'b0;
          nxt = at_bottom ? DOOR : MOVING;
        end else if (here_dir) begin
          nxt = DOOR;
        end else if (here_opp && (state == IDLE || !ahead)) begin
          dir_n = ~direction;
          nxt = DOOR;
        end else if (ahead) begin
          nxt = MOVING;
        end else if (behind && state == IDLE) begin
          dir_n = ~direction;
          nxt = MOVING;
        end else begin
          nxt = IDLE;
        end
      MOVING: nxt = move ? ARRIVE : MOVING;
      default: nxt = (recall && !at_bottom) || (!recall && !here_dir && dcnt >= D_LAST) ? IDLE : DOOR;
    endcase
    // every cycle that lands in DOOR retires the calls the open door serves
    clr_in = nxt == DOOR ? fbit : 8'h00;
    clr_up = dir_n ? clr_in : 8'h00;
    clr_dn = dir_n ? 8'h00 : clr_in;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      call_in <= 8'h00;
      call_up <= 8'h00;
      call_down <= 8'h00;
      cur_floor <= 3'd0;
      direction <= 1'b1;
      mcnt <= '0;
      dcnt <= '0;
    end else begin
      state <= nxt;
      direction <= dir_n;
      call_in <= recall ? 8'h00 : (call_in & ~clr_in) | call_in_req;
      call_up <= recall ? 8'h00 : (call_up & ~clr_up) | (call_up_req & 8'h7f);
      call_down <= recall ? 8'h00 : (call_down & ~clr_dn) | (call_down_req & 8'hfe);
      mcnt <= state == MOVING && !move ? mcnt + 1'b1 : '0;
      // an absorbed call counts its own cycle as the first of a fresh door period
      dcnt <= state != DOOR || recall ? '0 : here_dir ? DW'(1) : dcnt + 1'b1;
      if (move)
        cur_floor <= direction ? (cur_floor == 3'd7 ? 3'd7 : cur_floor + 3'd1)
                               : (at_bottom ? 3'd0 : cur_floor - 3'd1);
    end
  end
endmodule
